// File: rtl/f_fetch_seq_pkg.sv
// Shared constants and types for the MIPS fetch-stage sequencer.
// Holds the FSM encodings, the reset PC, the nop encoding and the buffered fetch entry.
package f_fetch_seq_pkg;

    localparam logic [0:0]  F_IDLE    = 1'b0;
    localparam logic [0:0]  F_REQ     = 1'b1;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } fetch_entry_t;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/f_fetch_seq_if.sv
// Instruction-memory req/ack port between the fetch sequencer (master) and memory (slave).
interface f_fetch_seq_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/f_fetch_seq_skid_buf.sv
// One-entry skid buffer holding a fetched instruction while F/D is stalled.
// A push on the same edge as a pop or flush wins and leaves the entry valid.
module f_skid_buf
    import f_fetch_seq_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t entry_i,
    output logic         valid_o,
    output fetch_entry_t entry_o
);

    logic         valid_q;
    logic         valid_d;
    fetch_entry_t entry_q;
    fetch_entry_t entry_d;

    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        if (push_i) begin
            valid_d = 1'b1;
            entry_d = entry_i;
        end else if (pop_i || flush_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign valid_o = valid_q;
    assign entry_o = entry_q;

endmodule

// File: rtl/f_fetch_seq.sv
// Fetch-stage sequencer: owns the fetch PC, runs the imem req/ack port, applies D-stage
// redirects after the delay slot, and buffers fetches against stalls. Optional macro: FETCH_ALIGN_CHECK_EN.
module f_fetch_seq
    import f_fetch_seq_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          stall_i,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    input  logic [31:0]   d_pc,
    f_fetch_seq_if.master imem,
    output logic          f_valid,
    output logic [31:0]   f_pc,
    output logic [31:0]   f_instr,
    output logic          f_adel
);

    logic [0:0]   state_q, state_d;
    logic         run_q;
    logic [31:0]  pc_q, pc_d;
    logic         f_valid_q, f_valid_d;
    fetch_entry_t f_out_q, f_out_d;
    logic         rd_pend_q, rd_pend_d;
    logic [31:0]  rd_tgt_q, rd_tgt_d;
    logic [31:0]  rd_slot_q, rd_slot_d;
    logic         drop_q, drop_d;

    logic         imem_req_w;
    logic [31:0]  imem_addr_w;
    logic         comp;
    logic         consume;
    logic         acc;
    logic [31:0]  slot;
    logic         acc_pend;
    logic         acc_late;
    logic         pend_eff;
    logic [31:0]  tgt_eff;
    logic [31:0]  slot_eff;
    logic         drop_eff;
    logic         comp_keep;
    logic         fetch_adel;
    fetch_entry_t fetch_entry;

    logic         sk_valid;
    fetch_entry_t sk_entry;
    logic         sk_flush;
    logic         sk_live;
    logic         sk_pop;
    logic         sk_push;
    logic         sk_full_next;
    logic         out_free;
    logic         out_from_fetch;

    // run_q keeps req low until the first edge after reset release.
    assign imem_req_w = run_q && (state_q == F_REQ);
    assign comp       = imem_req_w && imem.imem_ack;
    assign consume    = f_valid_q && !stall_i;
    assign acc        = redirect_valid && !stall_i;
    assign slot       = pc_plus4(d_pc);

`ifdef FETCH_ALIGN_CHECK_EN
    assign fetch_adel  = (pc_q[1:0] != 2'b00);
    assign imem_addr_w = pc_q;
`else
    assign fetch_adel  = 1'b0;
    assign imem_addr_w = {pc_q[31:2], 2'b00};
`endif

    assign fetch_entry = '{pc: pc_q,
                           instr: fetch_adel ? NOP_INSTR : imem.imem_rdata,
                           adel: fetch_adel};

    // Slot not yet fetched: park the target until the slot completes.
    // Otherwise the fetch at pc_q is wrong-path and gets replaced or dropped.
    assign acc_pend = acc && (pc_q <= slot);
    assign acc_late = acc && !(pc_q <= slot);

    // Merge an acceptance on this edge with the registered state so a completion
    // on the very same edge already sees it.
    assign pend_eff = rd_pend_q || acc_pend;
    assign tgt_eff  = acc_pend ? redirect_pc : rd_tgt_q;
    assign slot_eff = acc_pend ? slot : rd_slot_q;
    assign drop_eff = drop_q || (acc_late && imem_req_w);

    assign comp_keep = comp && !drop_eff;

    assign sk_flush       = acc && sk_valid && (sk_entry.pc == pc_plus4(slot));
    assign sk_live        = sk_valid && !sk_flush;
    assign out_free       = !f_valid_q || consume;
    assign sk_pop         = out_free && sk_live;
    assign out_from_fetch = out_free && !sk_live && comp_keep;
    assign sk_push        = comp_keep && !out_from_fetch;
    assign sk_full_next   = sk_push || (sk_live && !sk_pop);

    f_skid_buf u_skid (
        .clk     (clk),
        .reset   (reset),
        .push_i  (sk_push),
        .pop_i   (sk_pop),
        .flush_i (sk_flush),
        .entry_i (fetch_entry),
        .valid_o (sk_valid),
        .entry_o (sk_entry)
    );

    always_comb begin
        pc_d      = pc_q;
        rd_pend_d = rd_pend_q;
        rd_tgt_d  = rd_tgt_q;
        rd_slot_d = rd_slot_q;
        drop_d    = drop_q;

        if (acc_pend) begin
            rd_pend_d = 1'b1;
            rd_tgt_d  = redirect_pc;
            rd_slot_d = slot;
        end

        if (acc_late) begin
            if (!imem_req_w) begin
                pc_d = redirect_pc;
            end else if (!comp) begin
                drop_d   = 1'b1;
                rd_tgt_d = redirect_pc;
            end
        end

        if (comp) begin
            if (drop_eff) begin
                pc_d   = drop_q ? rd_tgt_q : redirect_pc;
                drop_d = 1'b0;
            end else if (pend_eff && (pc_q == slot_eff)) begin
                pc_d      = tgt_eff;
                rd_pend_d = 1'b0;
            end else begin
                pc_d = pc_plus4(pc_q);
            end
        end
    end

    always_comb begin
        f_valid_d = f_valid_q;
        f_out_d   = f_out_q;
        if (sk_pop) begin
            f_valid_d = 1'b1;
            f_out_d   = sk_entry;
        end else if (out_from_fetch) begin
            f_valid_d = 1'b1;
            f_out_d   = fetch_entry;
        end else if (consume) begin
            f_valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            F_REQ:   if (comp && sk_full_next) state_d = F_IDLE;
            F_IDLE:  if (!sk_valid && out_free) state_d = F_REQ;
            default: state_d = F_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= F_REQ;
            run_q     <= 1'b0;
            pc_q      <= RESET_PC;
            f_valid_q <= 1'b0;
            f_out_q   <= '0;
            rd_pend_q <= 1'b0;
            rd_tgt_q  <= '0;
            rd_slot_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= 1'b1;
            pc_q      <= pc_d;
            f_valid_q <= f_valid_d;
            f_out_q   <= f_out_d;
            rd_pend_q <= rd_pend_d;
            rd_tgt_q  <= rd_tgt_d;
            rd_slot_q <= rd_slot_d;
            drop_q    <= drop_d;
        end
    end

    assign imem.imem_req  = imem_req_w;
    assign imem.imem_addr = imem_addr_w;

    assign f_valid = f_valid_q;
    assign f_pc    = f_out_q.pc;
    assign f_instr = f_out_q.instr;
    assign f_adel  = f_out_q.adel;

endmodule
